// File: rtl/adv7611_bringup_ctrl.sv
// -----------------------------------------------------------------------------
// adv7611_bringup_ctrl
//
// Brings up an ADV7611 HDMI receiver. The sequence is:
//   1. Pulse the receiver hardware reset.
//   2. Wait a settle time.
//   3. Release the I2C LUT configurator and wait for it to report done or error.
//   4. Confirm video lock by counting in-time VS rising edges.
// Failed attempts (config error, config timeout, lock timeout) are retried up
// to MAX_RETRY times, then the block parks in FAIL. Once locked, VS is watched
// continuously and a loss of video restarts the sequence.
//
// Ports:
//   i_sys_clk        system clock (CLK_FRE MHz)
//   i_sys_rst        synchronous active-high reset
//   i_reinit         single-cycle pulse, restarts bring-up from any state
//   i_vs_async       receiver VS from the pixel clock domain (synchronised here)
//   i_cfg_done       configurator done level
//   i_cfg_error      configurator error level
//   o_adv7611_rst_n  receiver hardware reset, active low
//   o_cfg_rst_n      configurator reset, active low; its rising edge starts a pass
//   o_video_locked   high only in LOCKED
//   o_fail           high only in FAIL
//   o_state          current state encoding (debug/observability)
//   o_retry_cnt      failed attempts in the current bring-up
//   o_loss_cnt       lock-loss events, saturating at 255
// -----------------------------------------------------------------------------
module adv7611_bringup_ctrl #(
    parameter int CLK_FRE        = 25,
    parameter int RST_LOW_MS     = 10,
    parameter int RST_WAIT_MS    = 5,
    parameter int CFG_TIMEOUT_MS = 500,
    parameter int VS_TIMEOUT_MS  = 100,
    parameter int LOCK_FRAMES    = 4,
    parameter int MAX_RETRY      = 3
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_reinit,
    input  logic       i_vs_async,
    input  logic       i_cfg_done,
    input  logic       i_cfg_error,
    output logic       o_adv7611_rst_n,
    output logic       o_cfg_rst_n,
    output logic       o_video_locked,
    output logic       o_fail,
    output logic [2:0] o_state,
    output logic [2:0] o_retry_cnt,
    output logic [7:0] o_loss_cnt
);

    localparam int TICK_CYC = CLK_FRE * 1000;
    localparam int PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int MS_W     = 16;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RST_ASSERT = 3'd1,
        S_RST_WAIT   = 3'd2,
        S_CONFIG     = 3'd3,
        S_LOCK_WAIT  = 3'd4,
        S_LOCKED     = 3'd5,
        S_RETRY      = 3'd6,
        S_FAIL       = 3'd7
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              entry;
    logic              first_q;
    logic              vs_meta;
    logic              vs_sync;
    logic              vs_dly;
    logic              vs_rise;
    logic [PRE_W-1:0]  pre_cnt;
    logic [MS_W-1:0]   ms_cnt;
    logic              tick_end;
    logic              rst_low_done;
    logic              rst_wait_done;
    logic              cfg_timeout;
    logic              vs_timeout;
    logic [3:0]        frame_cnt;
    logic [2:0]        retry_q;
    logic [7:0]        loss_q;
    logic              loss_event;
    logic              rst_n_d;
    logic              cfg_rst_n_d;

    assign vs_rise = vs_sync & ~vs_dly;

    // A timeout of N ms fires on the last cycle of the Nth ms since the timer
    // was last cleared, so the state lasts exactly N*TICK_CYC cycles.
    assign tick_end      = (pre_cnt == PRE_W'(TICK_CYC - 1));
    assign rst_low_done  = tick_end && (ms_cnt == MS_W'(RST_LOW_MS - 1));
    assign rst_wait_done = tick_end && (ms_cnt == MS_W'(RST_WAIT_MS - 1));
    assign cfg_timeout   = tick_end && (ms_cnt == MS_W'(CFG_TIMEOUT_MS - 1));
    assign vs_timeout    = tick_end && (ms_cnt == MS_W'(VS_TIMEOUT_MS - 1));

    // A reinit into the current state still counts as a fresh entry.
    assign entry = (state_d != state_q) || i_reinit;

    assign o_state     = state_q;
    assign o_retry_cnt = retry_q;
    assign o_loss_cnt  = loss_q;

    always_comb begin
        state_d    = state_q;
        loss_event = 1'b0;
        case (state_q)
            S_IDLE:       state_d = S_RST_ASSERT;
            S_RST_ASSERT: if (rst_low_done) state_d = S_RST_WAIT;
            S_RST_WAIT:   if (rst_wait_done) state_d = S_CONFIG;
            S_CONFIG: begin
                // The configurator is still leaving reset on the first cycle,
                // so its done/error levels are not trusted yet.
                if (!first_q && i_cfg_error)     state_d = S_RETRY;
                else if (!first_q && i_cfg_done) state_d = S_LOCK_WAIT;
                else if (cfg_timeout)            state_d = S_RETRY;
            end
            S_LOCK_WAIT: begin
                if (vs_rise) begin
                    if (frame_cnt == 4'(LOCK_FRAMES - 1)) state_d = S_LOCKED;
                end else if (vs_timeout) begin
                    state_d = S_RETRY;
                end
            end
            S_LOCKED: begin
                if (!vs_rise && vs_timeout) begin
                    state_d    = S_RST_ASSERT;
                    loss_event = 1'b1;
                end
            end
            S_RETRY:  state_d = (retry_q == 3'(MAX_RETRY)) ? S_FAIL : S_RST_ASSERT;
            S_FAIL:   state_d = S_FAIL;
            default:  state_d = S_IDLE;
        endcase
        if (i_reinit) begin
            state_d    = S_RST_ASSERT;
            loss_event = 1'b0;
        end

        rst_n_d     = !((state_d == S_IDLE) || (state_d == S_RST_ASSERT));
        cfg_rst_n_d = (state_d == S_CONFIG) || (state_d == S_LOCK_WAIT) ||
                      (state_d == S_LOCKED);
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q         <= S_IDLE;
            first_q         <= 1'b0;
            vs_meta         <= 1'b0;
            vs_sync         <= 1'b0;
            vs_dly          <= 1'b0;
            pre_cnt         <= '0;
            ms_cnt          <= '0;
            frame_cnt       <= '0;
            retry_q         <= '0;
            loss_q          <= '0;
            o_adv7611_rst_n <= 1'b0;
            o_cfg_rst_n     <= 1'b0;
            o_video_locked  <= 1'b0;
            o_fail          <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= entry;

            vs_meta <= i_vs_async;
            vs_sync <= vs_meta;
            vs_dly  <= vs_sync;

            if (entry || vs_rise) begin
                pre_cnt <= '0;
                ms_cnt  <= '0;
            end else if (tick_end) begin
                pre_cnt <= '0;
                ms_cnt  <= ms_cnt + MS_W'(1);
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end

            if (entry) begin
                frame_cnt <= '0;
            end else if ((state_q == S_LOCK_WAIT) && vs_rise) begin
                frame_cnt <= frame_cnt + 4'd1;
            end

            // The count is bumped on entry to RETRY so RETRY itself can see the
            // new value when deciding between another attempt and FAIL.
            if (i_reinit || (entry && (state_d == S_LOCKED))) begin
                retry_q <= '0;
            end else if (entry && (state_d == S_RETRY)) begin
                retry_q <= retry_q + 3'd1;
            end

            if (loss_event && (loss_q != 8'hFF)) begin
                loss_q <= loss_q + 8'd1;
            end

            o_adv7611_rst_n <= rst_n_d;
            o_cfg_rst_n     <= cfg_rst_n_d;
            o_video_locked  <= (state_d == S_LOCKED);
            o_fail          <= (state_d == S_FAIL);
        end
    end

endmodule

// File: doc/adv7611_bringup_ctrl.md
Name: adv7611_bringup_ctrl

Overview:
- Sequences ADV7611 receiver bring-up: hardware reset pulse, settle delay, release of the I2C LUT configurator, wait for config done/error, then confirmation of video lock by counting VS edges.
- Retries on config error, config timeout or lock timeout. After lock, watches VS continuously and re-initialises on loss of video.
- Sits between the key-derived system reset and the existing i2c_config / ADV7611 reset pins. It replaces the direct `rst_n = ~sys_rst` tie.

Parameters:
- CLK_FRE, 25, system clock in MHz; one ms tick = CLK_FRE*1000 cycles.
- RST_LOW_MS, 10, ADV7611 reset-low duration in ms.
- RST_WAIT_MS, 5, settle time after reset release before config starts, in ms.
- CFG_TIMEOUT_MS, 500, maximum time in CONFIG before a retry.
- VS_TIMEOUT_MS, 100, maximum gap between VS rising edges.
- LOCK_FRAMES, 4, consecutive in-time VS edges required to declare lock (valid range 1..15).
- MAX_RETRY, 3, failed attempts before FAIL (valid range 1..7).

Ports:
- i_sys_clk  input  1  system clock (25 MHz board clock).
- i_sys_rst  input  1  synchronous, active-high reset.
- i_reinit  input  1  single-cycle pulse; restarts bring-up from any state.
- i_vs_async  input  1  ADV7611 VS in the pixel clock domain; synchronised internally.
- i_cfg_done  input  1  i2c_config done level.
- i_cfg_error  input  1  i2c_config error level.
- o_adv7611_rst_n  output  1  ADV7611 hardware reset, active low.
- o_cfg_rst_n  output  1  i2c_config reset, active low; a low-to-high transition starts a config pass.
- o_video_locked  output  1  high only in LOCKED.
- o_fail  output  1  high only in FAIL.
- o_state  output  3  current state encoding.
- o_retry_cnt  output  3  failed attempts in the current bring-up.
- o_loss_cnt  output  8  lock-loss events, saturating at 255.

Behaviour:
- Clocking and reset:
  - Single clock domain. All outputs are registered.
  - Reset is synchronous, active-high. Reset values: o_adv7611_rst_n=0, o_cfg_rst_n=0, o_video_locked=0, o_fail=0, o_state=0, o_retry_cnt=0, o_loss_cnt=0. Internal counters clear.
- VS path:
  - i_vs_async passes through a 2-FF synchroniser plus one delay FF.
  - vs_rise = sync & ~delayed, so a VS edge is seen 3 cycles after the input edge.
- ms timer: the cycle prescaler and ms counter both clear on every state entry and on every vs_rise.
- States (o_state encoding):
  - IDLE=0: rst_n=0, cfg_rst_n=0. Next cycle goes to RST_ASSERT.
  - RST_ASSERT=1: rst_n=0, cfg_rst_n=0. After RST_LOW_MS, go to RST_WAIT.
  - RST_WAIT=2: rst_n=1, cfg_rst_n=0. After RST_WAIT_MS, go to CONFIG.
  - CONFIG=3: rst_n=1, cfg_rst_n=1.
    - i_cfg_error goes to RETRY. Error wins if done and error are high in the same cycle.
    - Otherwise i_cfg_done goes to LOCK_WAIT.
    - Otherwise CFG_TIMEOUT_MS elapsed goes to RETRY.
    - done/error are ignored during the first cycle in CONFIG, because the configurator is leaving reset.
  - LOCK_WAIT=4: cfg_rst_n stays 1.
    - Each vs_rise increments frame_cnt.
    - frame_cnt reaching LOCK_FRAMES goes to LOCKED.
    - VS_TIMEOUT_MS with no vs_rise goes to RETRY.
    - frame_cnt clears on entry.
  - LOCKED=5: o_video_locked=1. retry_cnt clears on entry.
    - vs_rise restarts the watchdog.
    - VS_TIMEOUT_MS with no edge: o_loss_cnt increments (saturating), then go to RST_ASSERT. retry_cnt is not incremented.
  - RETRY=6: one cycle. retry_cnt increments.
    - If the new value equals MAX_RETRY, go to FAIL.
    - Otherwise go to RST_ASSERT.
  - FAIL=7: rst_n=1, cfg_rst_n=0, o_fail=1. Stays here until i_reinit or i_sys_rst.
- i_reinit:
  - Highest priority after i_sys_rst, in every state including RST_ASSERT and CONFIG.
  - Next state is RST_ASSERT.
  - retry_cnt clears; o_loss_cnt is kept; o_video_locked and o_fail drop in the same cycle as the state change.
- Output timing: outputs are decoded from the next state, so they change in the same cycle o_state changes.
- Reset mid-operation: returns to IDLE immediately with all reset values, whatever the state.

Test Plan:
- Nominal bring-up (CLK_FRE=1, RST_LOW_MS=2, RST_WAIT_MS=1, LOCK_FRAMES=4, VS_TIMEOUT_MS=3):
  - o_adv7611_rst_n is low for 2000 cycles.
  - o_cfg_rst_n rises 1000 cycles later.
  - Pulsing i_cfg_done moves o_state to 4.
  - 4 VS edges 1500 cycles apart give o_video_locked=1, o_state=5, o_retry_cnt=0.
- Config error retry:
  - Assert i_cfg_error in CONFIG three times with MAX_RETRY=3.
  - o_retry_cnt goes 1, 2, then o_state=7 and o_fail=1.
  - o_cfg_rst_n=0 and o_adv7611_rst_n=1 hold until i_reinit.
- Simultaneous done+error: both high in the same cycle gives RETRY (o_state=6 for one cycle), not LOCK_WAIT.
- Lock loss:
  - In LOCKED, stop VS for 3000 cycles.
  - o_loss_cnt goes 0 to 1, o_video_locked drops, o_state=1, o_retry_cnt stays 0.
  - Re-lock succeeds.
- Config timeout: CFG_TIMEOUT_MS=2 with done/error never asserted gives RETRY after 2000 cycles in CONFIG.
- Async input and control priority:
  - i_reinit during CONFIG returns o_state to 1 next cycle with o_retry_cnt=0.
  - i_sys_rst during LOCKED forces all outputs to their reset values next cycle.
  - A VS pulse shorter than 1 cycle alignment still registers exactly 1 edge when held for at least 2 clocks.
